// File: rtl/keccak_pkg.sv
// Shared types and constants for the slice-serial Keccak-p round engine.
package keccak_pkg;

  localparam int SLICE_W            = 25;
  localparam int DEFAULT_ROUNDS_MAX = 24;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    SSTART,
    SRUN,
    DRAIN
  } engineState_e;

  function automatic int clampRounds(input int requested, input int roundsMax);
    return (requested > roundsMax) ? roundsMax : requested;
  endfunction

endpackage

// File: rtl/keccak_round_engine_if.sv
// Host-side load/result bus of the round engine.
interface keccak_round_engine_if #(
  parameter int NSTEP = 5
);
  logic             start;
  logic [4:0]       rounds;
  logic [NSTEP-1:0] stepEn;
  logic [24:0]      in;
  logic             inValid;
  logic             inReady;
  logic [24:0]      out;
  logic             outValid;
  logic             outReady;
  logic             busy;
  logic             done;
  logic             err;

  modport master (
    output start, rounds, stepEn, in, inValid, outReady,
    input  inReady, out, outValid, busy, done, err
  );

  modport slave (
    input  start, rounds, stepEn, in, inValid, outReady,
    output inReady, out, outValid, busy, done, err
  );
endinterface

// File: rtl/pingpong_mem.sv
// Two slice banks: reads come from the selected bank, writes go to either it or its partner.
module pingpong_mem
  import keccak_pkg::*;
#(
  parameter int DEPTH = 64
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clearSel,
  input  logic                     toggle,
  input  logic                     we,
  input  logic                     weOther,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [SLICE_W-1:0]       wdata,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output logic [SLICE_W-1:0]       rdata
);

  logic [SLICE_W-1:0] bank0 [DEPTH];
  logic [SLICE_W-1:0] bank1 [DEPTH];
  logic               sel;
  logic               wrBank;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sel <= 1'b0;
    end else if (clearSel) begin
      sel <= 1'b0;
    end else if (toggle) begin
      sel <= ~sel;
    end
  end

  assign wrBank = weOther ? ~sel : sel;

  // Contents are deliberately left uninitialised on reset.
  always_ff @(posedge clk) begin
    if (we) begin
      if (wrBank) begin
        bank1[waddr] <= wdata;
      end else begin
        bank0[waddr] <= wdata;
      end
    end
  end

  assign rdata = sel ? bank1[raddr] : bank0[raddr];

endmodule

// File: rtl/keccak_round_engine.sv
// Slice-serial Keccak-p round sequencer: loads a state, walks enabled step units per round, drains.
module keccak_round_engine
  import keccak_pkg::*;
#(
  parameter int LANE_W     = 64,
  parameter int ROUNDS_MAX = DEFAULT_ROUNDS_MAX,
  parameter int NSTEP      = 5
) (
  input  logic                     clk,
  input  logic                     rst,
  keccak_round_engine_if.slave     bus,
  output logic [SLICE_W-1:0]       stepIn,
  output logic [4:0]               roundIdx,
  output logic [NSTEP-1:0]         stepStart,
  input  logic [NSTEP-1:0]         stepPutInput,
  input  logic [NSTEP-1:0]         stepOutReady,
  input  logic [SLICE_W*NSTEP-1:0] stepOut,
  input  logic [NSTEP-1:0]         stepReady
);

  localparam int PTR_W = $clog2(LANE_W);
  localparam int RND_W = $clog2(ROUNDS_MAX + 1);
  localparam int SW    = (NSTEP > 1) ? $clog2(NSTEP) : 1;
  localparam logic [6:0]       FULL     = 7'(LANE_W);
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(LANE_W - 1);

  engineState_e       state, stateNext;
  logic [PTR_W-1:0]   rdPtr, wrPtr;
  logic [6:0]         wrCnt, wrCntAfter;
  logic [RND_W-1:0]   round, nrEff, nrClamp;
  logic [NSTEP-1:0]   mask;
  logic [SW-1:0]      s, firstEn, nextEn;
  logic               hasNext;
  logic               errQ, doneQ;

  logic               selPut, selOutRdy, selRdy;
  logic [SLICE_W-1:0] selData, rdData, memWdata;
  logic               wrFull, wrAccept, stepGood, lastLoad, roundLast;
  logic               memWe, memWeOther, memToggle, memClrSel;

  pingpong_mem #(.DEPTH(LANE_W)) mem (
    .clk      (clk),
    .rst      (rst),
    .clearSel (memClrSel),
    .toggle   (memToggle),
    .we       (memWe),
    .weOther  (memWeOther),
    .waddr    (wrPtr),
    .wdata    (memWdata),
    .raddr    (rdPtr),
    .rdata    (rdData)
  );

  assign nrClamp   = RND_W'(clampRounds(int'(bus.rounds), ROUNDS_MAX));
  assign selPut    = stepPutInput[s];
  assign selOutRdy = stepOutReady[s];
  assign selRdy    = stepReady[s];
  assign selData   = stepOut[SLICE_W*int'(s) +: SLICE_W];

  assign wrFull     = (wrCnt == FULL);
  assign wrAccept   = (state == SRUN) && selOutRdy && !wrFull;
  assign wrCntAfter = wrCnt + {6'd0, wrAccept};
  // A final write landing together with stepReady still completes the step.
  assign stepGood   = (state == SRUN) && selRdy && (wrCntAfter == FULL);
  assign lastLoad   = (state == LOAD) && bus.inValid && (wrPtr == LAST_PTR);
  assign roundLast  = (RND_W'(round + 1'b1) == nrEff);

  always_comb begin
    firstEn = '0;
    nextEn  = '0;
    hasNext = 1'b0;
    for (int unsigned i = NSTEP; i > 0; i--) begin
      if (mask[i-1]) firstEn = SW'(i - 1);
    end
    for (int unsigned i = 0; i < NSTEP; i++) begin
      if (!hasNext && mask[i] && (SW'(i) > s)) begin
        nextEn  = SW'(i);
        hasNext = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= stateNext;
    end
  end

  always_comb begin
    stateNext    = state;
    bus.inReady  = 1'b0;
    bus.outValid = 1'b0;
    bus.out      = '0;
    bus.busy     = (state != IDLE);
    bus.done     = doneQ;
    bus.err      = errQ;
    stepIn       = rdData;
    stepStart    = '0;
    roundIdx     = '0;
    memWe        = 1'b0;
    memWeOther   = 1'b0;
    memToggle    = 1'b0;
    memClrSel    = 1'b0;
    memWdata     = bus.in;

    unique case (state)
      IDLE: begin
        if (bus.start) begin
          memClrSel = 1'b1;
          stateNext = LOAD;
        end
      end
      LOAD: begin
        bus.inReady = 1'b1;
        memWe       = bus.inValid;
        if (lastLoad) stateNext = (nrEff == '0) ? DRAIN : SSTART;
      end
      SSTART: begin
        roundIdx = 5'(ROUNDS_MAX) - 5'(nrEff) + 5'(round);
        if (mask == '0) begin
          if (roundLast) stateNext = DRAIN;
        end else begin
          stepStart[s] = 1'b1;
          stateNext    = SRUN;
        end
      end
      SRUN: begin
        roundIdx   = 5'(ROUNDS_MAX) - 5'(nrEff) + 5'(round);
        memWe      = wrAccept;
        memWeOther = 1'b1;
        memWdata   = selData;
        memToggle  = stepGood;
        if (selRdy) stateNext = (!hasNext && roundLast) ? DRAIN : SSTART;
      end
      DRAIN: begin
        bus.outValid = 1'b1;
        bus.out      = rdData;
        if (bus.outReady && (rdPtr == LAST_PTR)) stateNext = IDLE;
      end
      default: stateNext = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdPtr <= '0;
      wrPtr <= '0;
      wrCnt <= '0;
      round <= '0;
      nrEff <= '0;
      mask  <= '0;
      s     <= '0;
      errQ  <= 1'b0;
      doneQ <= 1'b0;
    end else begin
      doneQ <= 1'b0;
      unique case (state)
        IDLE: begin
          if (bus.start) begin
            errQ  <= 1'b0;
            rdPtr <= '0;
            wrPtr <= '0;
            wrCnt <= '0;
            round <= '0;
            nrEff <= nrClamp;
            mask  <= bus.stepEn;
          end
        end
        LOAD: begin
          if (bus.inValid) wrPtr <= wrPtr + 1'b1;
          if (lastLoad) begin
            round <= '0;
            s     <= firstEn;
          end
        end
        SSTART: begin
          rdPtr <= '0;
          wrPtr <= '0;
          wrCnt <= '0;
          if (mask == '0) round <= round + 1'b1;
        end
        SRUN: begin
          if (selPut) rdPtr <= rdPtr + 1'b1;
          if (selOutRdy) begin
            if (wrFull) begin
              errQ <= 1'b1;
            end else begin
              wrPtr <= wrPtr + 1'b1;
              wrCnt <= wrCnt + 1'b1;
            end
          end
          if (selRdy) begin
            if (!stepGood) errQ <= 1'b1;
            if (hasNext) begin
              s <= nextEn;
            end else begin
              s     <= firstEn;
              round <= round + 1'b1;
              if (roundLast) rdPtr <= '0;
            end
          end
        end
        DRAIN: begin
          if (bus.outReady) begin
            rdPtr <= rdPtr + 1'b1;
            if (rdPtr == LAST_PTR) doneQ <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_keccak_round_engine.sv
// Randomized bench for keccak_round_engine with behavioural step units and a round/step model.
module tb_keccak_round_engine;

  localparam int LW = 64;
  localparam int RM = 24;
  localparam int NS = 5;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  keccak_round_engine_if #(.NSTEP(NS)) bus();

  logic [24:0]      stepIn;
  logic [4:0]       roundIdx;
  logic [NS-1:0]    stepStart;
  logic [NS-1:0]    stepPutInput;
  logic [NS-1:0]    stepOutReady;
  logic [25*NS-1:0] stepOut;
  logic [NS-1:0]    stepReady;

  keccak_round_engine #(.LANE_W(LW), .ROUNDS_MAX(RM), .NSTEP(NS)) dut (
    .clk          (clk),
    .rst          (rst),
    .bus          (bus),
    .stepIn       (stepIn),
    .roundIdx     (roundIdx),
    .stepStart    (stepStart),
    .stepPutInput (stepPutInput),
    .stepOutReady (stepOutReady),
    .stepOut      (stepOut),
    .stepReady    (stepReady)
  );

  int passed;
  int total;

  // Unit behaviour: 0 identity, 1 echo roundIdx, 2 unit 2 flips LSB, 3 one extra write, 4 one write short
  int unitMode;

  logic [24:0] inData [LW];
  logic [24:0] got    [LW];
  logic [24:0] expOut [LW];
  int          expIdx [$];
  int          rIdxQ  [$];
  int          startCnt = 0;

  int   idxBase, startBase, startsSeen, holdErrs;
  bit   timeout;
  logic gotDone1, gotDone2, gotErr, gotBusy, gotValidAfter;

  always @(negedge clk) begin
    if (!rst && stepStart != '0) begin
      startCnt <= startCnt + 1;
      rIdxQ.push_back(int'(roundIdx));
    end
  end

  initial begin
    int k;
    int nW;
    logic [24:0] d;
    stepPutInput = '0;
    stepOutReady = '0;
    stepReady    = '0;
    stepOut      = '0;
    forever begin
      @(negedge clk);
      stepPutInput = '0;
      stepOutReady = '0;
      stepReady    = '0;
      if (!rst && stepStart != '0) begin
        k = 0;
        for (int j = 0; j < NS; j++) if (stepStart[j]) k = j;
        nW = (unitMode == 3) ? LW + 1 : (unitMode == 4) ? LW - 1 : LW;
        for (int i = 0; i < nW; i++) begin
          @(negedge clk);
          if (rst) break;
          stepPutInput    = '0;
          stepOutReady    = '0;
          stepReady       = '0;
          stepPutInput[k] = 1'b1;
          stepOutReady[k] = 1'b1;
          if (i == nW - 1) stepReady[k] = 1'b1;
          if (unitMode == 1) d = 25'(roundIdx);
          else if (unitMode == 2 && k == 2) d = stepIn ^ 25'h1;
          else d = stepIn;
          stepOut[25*k +: 25] = d;
        end
      end
    end
  end

  initial begin
    #3000000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  // Round-by-round model: each enabled step maps every slice through its unit function.
  task automatic buildModel(input int nr, input logic [NS-1:0] mask, input int mode);
    int nrEff;
    nrEff = (nr > RM) ? RM : nr;
    expIdx.delete();
    for (int j = 0; j < LW; j++) expOut[j] = inData[j];
    for (int r = 0; r < nrEff; r++) begin
      for (int st = 0; st < NS; st++) begin
        if (mask[st]) begin
          expIdx.push_back(RM - nrEff + r);
          for (int j = 0; j < LW; j++) begin
            if (mode == 1) expOut[j] = 25'(RM - nrEff + r);
            else if (mode == 2 && st == 2) expOut[j] = expOut[j] ^ 25'h1;
          end
        end
      end
    end
  endtask

  task automatic loadOp(input int nr, input logic [NS-1:0] mask);
    @(negedge clk);
    bus.start  = 1'b1;
    bus.rounds = 5'(nr);
    bus.stepEn = mask;
    @(negedge clk);
    bus.start = 1'b0;
    for (int i = 0; i < LW; i++) begin
      bus.inValid = 1'b0;
      repeat ($urandom_range(0, 1)) @(negedge clk);
      bus.in      = inData[i];
      bus.inValid = 1'b1;
      @(negedge clk);
    end
    bus.inValid = 1'b0;
  endtask

  task automatic captureOp(input bit toggle);
    int idx;
    int cyc;
    bit rdy;
    bit holdPending;
    logic [24:0] holdVal;
    idx = 0; cyc = 0; holdPending = 0; holdVal = '0;
    timeout = 0; holdErrs = 0;
    while (idx < LW) begin
      @(negedge clk);
      cyc++;
      if (cyc > 30000) begin
        timeout = 1;
        break;
      end
      if (holdPending) begin
        if (!bus.outValid || bus.out !== holdVal) holdErrs++;
        holdPending = 0;
      end
      rdy = toggle ? cyc[0] : 1'b1;
      bus.outReady = rdy;
      if (bus.outValid) begin
        if (rdy) begin
          got[idx] = bus.out;
          idx++;
        end else begin
          holdPending = 1;
          holdVal     = bus.out;
        end
      end
    end
    @(negedge clk);
    bus.outReady  = 1'b0;
    gotDone1      = bus.done;
    gotBusy       = bus.busy;
    gotErr        = bus.err;
    gotValidAfter = bus.outValid;
    @(negedge clk);
    gotDone2 = bus.done;
    startsSeen = startCnt - startBase;
  endtask

  task automatic runOp(input int nr, input logic [NS-1:0] mask, input int mode, input bit toggle, input bit midStart);
    unitMode = mode;
    for (int j = 0; j < LW; j++) inData[j] = 25'($urandom);
    buildModel(nr, mask, mode);
    idxBase   = rIdxQ.size();
    startBase = startCnt;
    loadOp(nr, mask);
    if (midStart) begin
      repeat (5) @(negedge clk);
      bus.start  = 1'b1;
      bus.rounds = 5'd1;
      bus.stepEn = 5'b00001;
      @(negedge clk);
      bus.start = 1'b0;
    end
    captureOp(toggle);
  endtask

  task automatic test_reset();
    #1;
    total++; if (bus.inReady !== 1'b0) $display("FAIL reset_inReady got=%0b want=0", bus.inReady); else passed++;
    total++; if (bus.outValid !== 1'b0) $display("FAIL reset_outValid got=%0b want=0", bus.outValid); else passed++;
    total++; if (bus.busy !== 1'b0) $display("FAIL reset_busy got=%0b want=0", bus.busy); else passed++;
    total++; if (bus.done !== 1'b0) $display("FAIL reset_done got=%0b want=0", bus.done); else passed++;
    total++; if (bus.err !== 1'b0) $display("FAIL reset_err got=%0b want=0", bus.err); else passed++;
    total++; if (stepStart !== '0) $display("FAIL reset_stepStart got=%b want=0", stepStart); else passed++;
    total++; if (roundIdx !== 5'd0) $display("FAIL reset_roundIdx got=%0d want=0", roundIdx); else passed++;
    total++; if (bus.out !== 25'd0) $display("FAIL reset_out got=%h want=0", bus.out); else passed++;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_identity();
    runOp(24, 5'b11111, 0, 1'b0, 1'b1);
    total++; if (timeout !== 1'b0) $display("FAIL ident_timeout got=%0b want=0", timeout); else passed++;
    for (int j = 0; j < LW; j++) begin
      total++; if (got[j] !== expOut[j]) $display("FAIL ident_slice%0d got=%h want=%h", j, got[j], expOut[j]); else passed++;
    end
    total++; if (startsSeen !== expIdx.size()) $display("FAIL ident_starts got=%0d want=%0d", startsSeen, expIdx.size()); else passed++;
    for (int j = 0; j < expIdx.size(); j++) begin
      total++; if (rIdxQ[idxBase+j] !== expIdx[j]) $display("FAIL ident_roundIdx%0d got=%0d want=%0d", j, rIdxQ[idxBase+j], expIdx[j]); else passed++;
    end
    total++; if (gotDone1 !== 1'b1) $display("FAIL ident_done got=%0b want=1", gotDone1); else passed++;
    total++; if (gotDone2 !== 1'b0) $display("FAIL ident_done_width got=%0b want=0", gotDone2); else passed++;
    total++; if (gotErr !== 1'b0) $display("FAIL ident_err got=%0b want=0", gotErr); else passed++;
    total++; if (gotBusy !== 1'b0) $display("FAIL ident_busy_after got=%0b want=0", gotBusy); else passed++;
    total++; if (gotValidAfter !== 1'b0) $display("FAIL ident_extra_slice got=%0b want=0", gotValidAfter); else passed++;
  endtask

  task automatic test_round_offset();
    runOp(12, 5'b11111, 1, 1'b0, 1'b0);
    total++; if (startsSeen !== 60) $display("FAIL offset12_starts got=%0d want=60", startsSeen); else passed++;
    for (int j = 0; j < expIdx.size(); j++) begin
      total++; if (rIdxQ[idxBase+j] !== expIdx[j]) $display("FAIL offset12_roundIdx%0d got=%0d want=%0d", j, rIdxQ[idxBase+j], expIdx[j]); else passed++;
    end
    for (int j = 0; j < LW; j += 9) begin
      total++; if (got[j] !== expOut[j]) $display("FAIL offset12_slice%0d got=%h want=%h", j, got[j], expOut[j]); else passed++;
    end
    runOp(30, 5'b00001, 1, 1'b0, 1'b0);
    total++; if (startsSeen !== RM) $display("FAIL clamp_starts got=%0d want=%0d", startsSeen, RM); else passed++;
    total++; if (rIdxQ[idxBase] !== 0) $display("FAIL clamp_firstIdx got=%0d want=0", rIdxQ[idxBase]); else passed++;
    total++; if (got[LW-1] !== expOut[LW-1]) $display("FAIL clamp_slice got=%h want=%h", got[LW-1], expOut[LW-1]); else passed++;
  endtask

  task automatic test_zero_rounds();
    runOp(0, 5'b11111, 0, 1'b0, 1'b0);
    total++; if (startsSeen !== 0) $display("FAIL nr0_starts got=%0d want=0", startsSeen); else passed++;
    total++; if (gotDone1 !== 1'b1) $display("FAIL nr0_done got=%0b want=1", gotDone1); else passed++;
    for (int j = 0; j < LW; j++) begin
      total++; if (got[j] !== inData[j]) $display("FAIL nr0_slice%0d got=%h want=%h", j, got[j], inData[j]); else passed++;
    end
    runOp(3, 5'b00000, 0, 1'b0, 1'b0);
    total++; if (startsSeen !== 0) $display("FAIL mask0_starts got=%0d want=0", startsSeen); else passed++;
    total++; if (gotDone1 !== 1'b1) $display("FAIL mask0_done got=%0b want=1", gotDone1); else passed++;
    for (int j = 0; j < LW; j++) begin
      total++; if (got[j] !== inData[j]) $display("FAIL mask0_slice%0d got=%h want=%h", j, got[j], inData[j]); else passed++;
    end
  endtask

  task automatic test_xor();
    runOp(3, 5'b00100, 2, 1'b0, 1'b0);
    total++; if (startsSeen !== 3) $display("FAIL xor_starts got=%0d want=3", startsSeen); else passed++;
    for (int j = 0; j < LW; j++) begin
      total++; if (got[j] !== expOut[j]) $display("FAIL xor_slice%0d got=%h want=%h", j, got[j], expOut[j]); else passed++;
    end
  endtask

  task automatic test_backpressure_reset();
    int c0;
    int cyc;
    runOp(2, 5'b11111, 0, 1'b1, 1'b0);
    total++; if (holdErrs !== 0) $display("FAIL bp_hold got=%0d want=0", holdErrs); else passed++;
    total++; if (gotDone1 !== 1'b1) $display("FAIL bp_done got=%0b want=1", gotDone1); else passed++;
    for (int j = 0; j < LW; j++) begin
      total++; if (got[j] !== expOut[j]) $display("FAIL bp_slice%0d got=%h want=%h", j, got[j], expOut[j]); else passed++;
    end
    unitMode = 0;
    c0 = startCnt;
    loadOp(24, 5'b11111);
    cyc = 0;
    while (startCnt < c0 + 3 && cyc < 20000) begin
      @(negedge clk);
      cyc++;
    end
    total++; if (startCnt < c0 + 3) $display("FAIL midrst_reach got=%0d want=%0d", startCnt - c0, 3); else passed++;
    repeat ($urandom_range(5, 40)) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    total++; if (bus.busy !== 1'b0) $display("FAIL midrst_busy got=%0b want=0", bus.busy); else passed++;
    total++; if (stepStart !== '0 || roundIdx !== 5'd0) $display("FAIL midrst_step got=%b/%0d want=0/0", stepStart, roundIdx); else passed++;
    total++; if ({bus.inReady, bus.outValid, bus.done, bus.err} !== 4'b0) $display("FAIL midrst_flags got=%b want=0000", {bus.inReady, bus.outValid, bus.done, bus.err}); else passed++;
    total++; if (bus.out !== 25'd0) $display("FAIL midrst_out got=%h want=0", bus.out); else passed++;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    runOp(1, 5'b11111, 0, 1'b1, 1'b0);
    total++; if (holdErrs !== 0) $display("FAIL postrst_hold got=%0d want=0", holdErrs); else passed++;
    for (int j = 0; j < LW; j++) begin
      total++; if (got[j] !== expOut[j]) $display("FAIL postrst_slice%0d got=%h want=%h", j, got[j], expOut[j]); else passed++;
    end
  endtask

  task automatic test_err();
    runOp(1, 5'b00001, 3, 1'b0, 1'b0);
    total++; if (gotErr !== 1'b1) $display("FAIL overrun_err got=%0b want=1", gotErr); else passed++;
    total++; if (gotDone1 !== 1'b1) $display("FAIL overrun_done got=%0b want=1", gotDone1); else passed++;
    total++; if (got[5] !== expOut[5]) $display("FAIL overrun_slice got=%h want=%h", got[5], expOut[5]); else passed++;
    repeat (3) @(negedge clk);
    total++; if (bus.err !== 1'b1) $display("FAIL overrun_sticky got=%0b want=1", bus.err); else passed++;
    runOp(1, 5'b00001, 0, 1'b0, 1'b0);
    total++; if (gotErr !== 1'b0) $display("FAIL err_cleared got=%0b want=0", gotErr); else passed++;
    runOp(1, 5'b00001, 4, 1'b0, 1'b0);
    total++; if (gotErr !== 1'b1) $display("FAIL underrun_err got=%0b want=1", gotErr); else passed++;
    total++; if (got[7] !== inData[7]) $display("FAIL underrun_keepbank got=%h want=%h", got[7], inData[7]); else passed++;
    unitMode = 0;
    @(negedge clk);
    bus.start  = 1'b1;
    bus.rounds = 5'd1;
    bus.stepEn = 5'b00001;
    @(negedge clk);
    bus.start = 1'b0;
    total++; if (bus.err !== 1'b0) $display("FAIL start_clears_err got=%0b want=0", bus.err); else passed++;
    total++; if (bus.inReady !== 1'b1) $display("FAIL load_inReady got=%0b want=1", bus.inReady); else passed++;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    passed       = 0;
    total        = 0;
    rst          = 1'b1;
    unitMode     = 0;
    bus.start    = 1'b0;
    bus.rounds   = '0;
    bus.stepEn   = '0;
    bus.in       = '0;
    bus.inValid  = 1'b0;
    bus.outReady = 1'b0;
    test_reset();
    test_identity();
    test_round_offset();
    test_zero_rounds();
    test_xor();
    test_backpressure_reset();
    test_err();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
